// File: rtl/pdua_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pdua_control_unit_if
// Description : Control/status bundle between the PDUA sequencer and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface pdua_control_unit_if #(
    parameter int ADDR_WIDTH = 3
);
    logic [4:0]            out_IR;
    logic                  C;
    logic                  N;
    logic                  P;
    logic                  Z;
    logic                  wr_rdn;
    logic                  enaf;
    logic [2:0]            selop;
    logic [1:0]            shamt;
    logic                  bank_wr_en;
    logic [ADDR_WIDTH-1:0] BusB_addr;
    logic [ADDR_WIDTH-1:0] BusC_addr;
    logic                  sclr;
    logic                  ir_en;
    logic                  mar_en;
    logic                  mdr_en;
    logic                  mdr_alu_n;
    logic                  halted;

    // Sequencer side
    modport master (
        input  out_IR, C, N, P, Z,
        output wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
               sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted
    );

    // Datapath side
    modport slave (
        output out_IR, C, N, P, Z,
        input  wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
               sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted
    );
endinterface
`default_nettype wire

// File: rtl/pdua_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : pdua_control_unit
// Description : Hardwired fetch/decode/execute sequencer for the PDUA datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module pdua_control_unit #(
    parameter int                    MAX_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = 3'd0,
    parameter logic [ADDR_WIDTH-1:0] ACC_ADDR   = 3'd1,
    parameter logic [ADDR_WIDTH-1:0] TMP_ADDR   = 3'd7
) (
    input  wire                      clk,
    input  wire                      rst,
    pdua_control_unit_if.master      bus
);

    localparam logic [4:0] c_op_nop  = 5'b00000;
    localparam logic [4:0] c_op_ldi  = 5'b00001;
    localparam logic [4:0] c_op_add  = 5'b00010;
    localparam logic [4:0] c_op_sub  = 5'b00011;
    localparam logic [4:0] c_op_and  = 5'b00100;
    localparam logic [4:0] c_op_or   = 5'b00101;
    localparam logic [4:0] c_op_shl  = 5'b00110;
    localparam logic [4:0] c_op_jmp  = 5'b00111;
    localparam logic [4:0] c_op_jz   = 5'b01000;
    localparam logic [4:0] c_op_sta  = 5'b01001;
    localparam logic [4:0] c_op_halt = 5'b11111;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH0 = 4'd1,
        S_FETCH1 = 4'd2,
        S_FETCH2 = 4'd3,
        S_DECODE = 4'd4,
        S_OPA0   = 4'd5,
        S_OPA1   = 4'd6,
        S_OPA2   = 4'd7,
        S_EXEC   = 4'd8,
        S_ST1    = 4'd9,
        S_ST2    = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    // Set by the first clock edge after reset release; holds sclr off until then.
    logic   r_run;

    wire w_unused_flags = &{1'b0, bus.C, bus.N, bus.P, MAX_WIDTH[0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_INIT;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:   w_state_nxt = r_run ? S_FETCH0 : S_INIT;
            S_FETCH0: w_state_nxt = S_FETCH1;
            S_FETCH1: w_state_nxt = S_FETCH2;
            S_FETCH2: w_state_nxt = S_DECODE;
            S_DECODE: begin
                if (bus.out_IR == c_op_halt)
                    w_state_nxt = S_HALT;
                else if (bus.out_IR >= c_op_ldi && bus.out_IR <= c_op_sta)
                    w_state_nxt = S_OPA0;
                else
                    w_state_nxt = S_FETCH0;
            end
            S_OPA0:   w_state_nxt = S_OPA1;
            S_OPA1:   w_state_nxt = S_OPA2;
            S_OPA2:   w_state_nxt = (bus.out_IR == c_op_ldi) ? S_FETCH0 : S_EXEC;
            S_EXEC:   w_state_nxt = (bus.out_IR == c_op_sta) ? S_ST1 : S_FETCH0;
            S_ST1:    w_state_nxt = S_ST2;
            S_ST2:    w_state_nxt = S_FETCH0;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        bus.wr_rdn     = 1'b0;
        bus.enaf       = 1'b0;
        bus.selop      = 3'b000;
        bus.shamt      = 2'b00;
        bus.bank_wr_en = 1'b0;
        bus.BusB_addr  = '0;
        bus.BusC_addr  = '0;
        bus.sclr       = 1'b0;
        bus.ir_en      = 1'b0;
        bus.mar_en     = 1'b0;
        bus.mdr_en     = 1'b0;
        bus.mdr_alu_n  = 1'b0;
        bus.halted     = 1'b0;
        case (r_state)
            S_INIT: bus.sclr = r_run;
            S_FETCH0, S_OPA0: begin
                bus.BusB_addr = PC_ADDR;
                bus.mar_en    = 1'b1;
            end
            // Memory read into MDR overlaps with PC increment
            S_FETCH1, S_OPA1: begin
                bus.mdr_en     = 1'b1;
                bus.BusB_addr  = PC_ADDR;
                bus.selop      = 3'b111;
                bus.bank_wr_en = 1'b1;
                bus.BusC_addr  = PC_ADDR;
            end
            S_FETCH2: bus.ir_en = 1'b1;
            S_OPA2: begin
                bus.mdr_alu_n  = 1'b1;
                bus.bank_wr_en = 1'b1;
                bus.BusC_addr  = (bus.out_IR == c_op_ldi) ? ACC_ADDR : TMP_ADDR;
            end
            S_EXEC: begin
                case (bus.out_IR)
                    c_op_add, c_op_sub, c_op_and, c_op_or: begin
                        bus.BusB_addr  = TMP_ADDR;
                        bus.enaf       = 1'b1;
                        bus.bank_wr_en = 1'b1;
                        bus.BusC_addr  = ACC_ADDR;
                        case (bus.out_IR)
                            c_op_add: bus.selop = 3'b001;
                            c_op_sub: bus.selop = 3'b010;
                            c_op_and: bus.selop = 3'b011;
                            default:  bus.selop = 3'b100;
                        endcase
                    end
                    c_op_shl: begin
                        bus.BusB_addr  = ACC_ADDR;
                        bus.selop      = 3'b110;
                        bus.shamt      = 2'b01;
                        bus.enaf       = 1'b1;
                        bus.bank_wr_en = 1'b1;
                        bus.BusC_addr  = ACC_ADDR;
                    end
                    c_op_jmp, c_op_jz: begin
                        bus.BusB_addr  = TMP_ADDR;
                        bus.BusC_addr  = PC_ADDR;
                        bus.bank_wr_en = (bus.out_IR == c_op_jmp) ? 1'b1 : bus.Z;
                    end
                    c_op_sta: begin
                        bus.BusB_addr = TMP_ADDR;
                        bus.mar_en    = 1'b1;
                    end
                    default: bus.selop = 3'b000;
                endcase
            end
            S_ST1: begin
                bus.BusB_addr = ACC_ADDR;
                bus.mdr_en    = 1'b1;
            end
            S_ST2:  bus.wr_rdn = 1'b1;
            S_HALT: bus.halted = 1'b1;
            default: bus.sclr = 1'b0;
        endcase
    end

endmodule
`default_nettype wire
